// File: rtl/mem_bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_bus_pkg : shared types and constants for the memory bus arbiter      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package mem_bus_pkg;

  localparam int DEF_AW = 13;
  localparam int DEF_DW = 8;

  localparam logic [12:0] RAM_BASE = 13'h1800;
  // Top two address bits that select RAM; everything else is ROM.
  localparam logic [1:0]  RAM_TAG  = RAM_BASE[12:11];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    REG_ROM = 1'b0,
    REG_RAM = 1'b1
  } region_t;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } port_t;

endpackage
`default_nettype wire

// File: rtl/mem_region_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_region_decode : combinational address -> ROM/RAM region              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_region_decode
  import mem_bus_pkg::*;
#(
  parameter int AW = DEF_AW
) (
  input  logic [AW-1:0] i_addr,
  output region_t       o_region
);

  assign o_region = (i_addr[AW-1 -: 2] == RAM_TAG) ? REG_RAM : REG_ROM;

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_bus_arbiter : shares the ROM/RAM bus between fetch and data ports.   |
// | MEM_ARB_RR_EN selects round-robin arbitration (default: data priority).  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int ROM_WAIT = 1,
  parameter int RAM_WAIT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  output logic          rom_sel,
  output logic          ram_sel,
  output logic          rd,
  output logic          wr
);

  localparam logic [2:0] c_rom_wait = 3'(ROM_WAIT);
  localparam logic [2:0] c_ram_wait = 3'(RAM_WAIT);

  state_t        r_state;
  port_t         r_gnt;
  logic [2:0]    r_wait;

  port_t         w_winner;
  logic [AW-1:0] w_addr;
  logic          w_we;
  region_t       w_region;

`ifdef MEM_ARB_RR_EN
  port_t r_last;

  // On contention the port that lost last time wins.
  always_comb begin
    w_winner = GNT_FETCH;
    if (if_req && d_req)
      w_winner = (r_last == GNT_DATA) ? GNT_FETCH : GNT_DATA;
    else if (d_req)
      w_winner = GNT_DATA;
  end
`else
  always_comb begin
    w_winner = d_req ? GNT_DATA : GNT_FETCH;
  end
`endif

  assign w_addr = (w_winner == GNT_DATA) ? d_addr : if_addr;
  assign w_we   = (w_winner == GNT_DATA) && d_we;

  // Decodes the address being latched, so the region travels with it.
  mem_region_decode #(
    .AW (AW)
  ) u_decode (
    .i_addr   (w_addr),
    .o_region (w_region)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gnt     <= GNT_FETCH;
      r_wait    <= 3'd0;
`ifdef MEM_ARB_RR_EN
      r_last    <= GNT_DATA;
`endif
      if_ack    <= 1'b0;
      if_rdata  <= '0;
      d_ack     <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rom_sel   <= 1'b0;
      ram_sel   <= 1'b0;
      rd        <= 1'b0;
      wr        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (if_req || d_req) begin
            r_gnt    <= w_winner;
`ifdef MEM_ARB_RR_EN
            r_last   <= w_winner;
`endif
            bus_addr <= w_addr;
            if (w_we && (w_region == REG_ROM)) begin
              // ROM is read-only: complete at once with an error, no strobe.
              r_state <= DONE;
              d_ack   <= 1'b1;
              d_err   <= 1'b1;
            end else begin
              r_state <= ACCESS;
              if (w_we)
                bus_wdata <= d_wdata;
              rd      <= ~w_we;
              wr      <= w_we;
              rom_sel <= (w_region == REG_ROM);
              ram_sel <= (w_region == REG_RAM);
              r_wait  <= (w_region == REG_RAM) ? c_ram_wait : c_rom_wait;
            end
          end
        end

        ACCESS: begin
          if (r_wait == 3'd0) begin
            r_state <= DONE;
            rd      <= 1'b0;
            wr      <= 1'b0;
            rom_sel <= 1'b0;
            ram_sel <= 1'b0;
            // Writes leave the read-data registers untouched.
            if (r_gnt == GNT_DATA) begin
              d_ack <= 1'b1;
              if (rd)
                d_rdata <= bus_rdata;
            end else begin
              if_ack <= 1'b1;
              if (rd)
                if_rdata <= bus_rdata;
            end
          end else begin
            r_wait <= r_wait - 3'd1;
          end
        end

        DONE: begin
          r_state <= IDLE;
          if_ack  <= 1'b0;
          d_ack   <= 1'b0;
          d_err   <= 1'b0;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_bus_arbiter : directed self-checking bench for mem_bus_arbiter    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [12:0] if_addr;
  logic        if_ack;
  logic [7:0]  if_rdata;
  logic        d_req;
  logic        d_we;
  logic [12:0] d_addr;
  logic [7:0]  d_wdata;
  logic        d_ack;
  logic [7:0]  d_rdata;
  logic        d_err;
  logic [12:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        rom_sel;
  logic        ram_sel;
  logic        rd;
  logic        wr;

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_arbiter #(
    .AW       (13),
    .DW       (8),
    .ROM_WAIT (1),
    .RAM_WAIT (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .rom_sel   (rom_sel),
    .ram_sel   (ram_sel),
    .rd        (rd),
    .wr        (wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents seen on the bus, keyed by address.
  always_comb begin
    case (bus_addr)
      13'h0010: bus_rdata = 8'hA5;
      13'h17FF: bus_rdata = 8'h11;
      13'h1800: bus_rdata = 8'h22;
      13'h1900: bus_rdata = 8'h5C;
      default:  bus_rdata = 8'hEE;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fetch read; exp_lat counts edges from request to visible ack.
  task automatic fetch(input logic [12:0] a, input logic [7:0] exp_d,
                       input logic exp_ram, input int exp_lat, input string tag);
    int n;
    if_req  = 1'b1;
    if_addr = a;
    tick();
    chk({tag, "_rom_sel"}, 32'(rom_sel), 32'(!exp_ram));
    chk({tag, "_ram_sel"}, 32'(ram_sel), 32'(exp_ram));
    chk({tag, "_rd"},      32'(rd),      32'd1);
    chk({tag, "_addr"},    32'(bus_addr), 32'(a));
    if_addr = ~a;
    n = 1;
    while (!if_ack && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"},   32'(n),        32'(exp_lat));
    chk({tag, "_rdata"}, 32'(if_rdata), 32'(exp_d));
    chk({tag, "_done_rd"}, 32'({rd, rom_sel, ram_sel}), 32'd0);
    if_req = 1'b0;
    tick();
    chk({tag, "_ack_drop"}, 32'(if_ack), 32'd0);
  endtask

  task automatic dwrite(input logic [12:0] a, input logic [7:0] wd,
                        input logic exp_err, input int exp_lat, input string tag);
    int n;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = a;
    d_wdata = wd;
    tick();
    if (!exp_err) begin
      chk({tag, "_wr"},    32'(wr),        32'd1);
      chk({tag, "_sel"},   32'({rom_sel, ram_sel}), 32'b01);
      chk({tag, "_wdata"}, 32'(bus_wdata), 32'(wd));
    end
    n = 1;
    while (!d_ack && n < 20) begin
      chk({tag, "_no_ack_strobe"}, 32'(rd), 32'd0);
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n),     32'(exp_lat));
    chk({tag, "_err"}, 32'(d_err), 32'(exp_err));
    chk({tag, "_strobes"}, 32'({rd, wr, rom_sel, ram_sel}), 32'd0);
    d_req = 1'b0;
    d_we  = 1'b0;
    tick();
    chk({tag, "_ack_drop"}, 32'({d_ack, d_err}), 32'd0);
  endtask

  initial begin
    int ic;
    int dc;
    rst     = 1'b1;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    tick();
    tick();
    chk("rst_outs", 32'({if_ack, d_ack, d_err, rom_sel, ram_sel, rd, wr}), 32'd0);
    chk("rst_addr", 32'(bus_addr), 32'd0);
    chk("rst_rdata", 32'({if_rdata, d_rdata}), 32'd0);
    rst = 1'b0;
    tick();

    fetch(13'h0010, 8'hA5, 1'b0, 3, "rom_fetch");
    dwrite(13'h1805, 8'h3C, 1'b0, 2, "ram_write");
    dwrite(13'h0800, 8'h99, 1'b1, 1, "rom_write");

    // Contention: fetch of 0x0010 against data read of 0x1900.
    if_req  = 1'b1;
    if_addr = 13'h0010;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 13'h1900;
    ic = 0;
    dc = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (if_ack && d_ack) chk("both_ack", 32'd1, 32'd0);
      if (d_ack && dc == 0) begin
        dc = c;
        chk("cont_d_rdata", 32'(d_rdata), 32'h5C);
        d_req = 1'b0;
      end
      if (if_ack && ic == 0) begin
        ic = c;
        chk("cont_if_rdata", 32'(if_rdata), 32'hA5);
        if_req = 1'b0;
      end
      if (ic != 0 && dc != 0) break;
    end
`ifdef MEM_ARB_RR_EN
    chk("cont_if_cycle", 32'(ic), 32'd3);
    chk("cont_d_cycle",  32'(dc), 32'd6);
`else
    chk("cont_d_cycle",  32'(dc), 32'd2);
    chk("cont_if_cycle", 32'(ic), 32'd6);
`endif
    if_req = 1'b0;
    d_req  = 1'b0;
    tick();
    tick();

    // Reset during the second ACCESS cycle of a ROM read.
    if_req  = 1'b1;
    if_addr = 13'h0010;
    tick();
    tick();
    chk("mid_rd_before", 32'({rd, rom_sel}), 32'b11);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_drop", 32'({rd, rom_sel, if_ack}), 32'd0);
    if_req = 1'b0;
    tick();
    chk("mid_rst_noack", 32'(if_ack), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_idle", 32'({if_ack, rd, rom_sel}), 32'd0);
    fetch(13'h0010, 8'hA5, 1'b0, 3, "rerequest");

    // Back-to-back fetches straddling the ROM/RAM boundary.
    fetch(13'h17FF, 8'h11, 1'b0, 3, "b2b_rom");
    fetch(13'h1800, 8'h22, 1'b1, 2, "b2b_ram");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 13-bit memory bus (ROM + RAM) between the instruction-fetch requester (read-only) and the data requester (read/write).
- Sequences each access through address setup, region-dependent wait states and completion; generates rom_sel/ram_sel, rd and wr strobes.
- Sits between the CPU core's fetch/execute units and the ROM/RAM macros; replaces direct core drive of the bus.

Parameters:
- AW, 13, address width
- DW, 8, data width
- ROM_WAIT, 1, extra wait cycles for ROM accesses (0..7)
- RAM_WAIT, 0, extra wait cycles for RAM accesses (0..7)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  AW  fetch address
- if_ack  out  1  one-cycle fetch completion pulse
- if_rdata  out  DW  fetch data, valid with if_ack
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  DW  read data, valid with d_ack
- d_err  out  1  pulses with d_ack on a rejected write to ROM
- bus_addr  out  AW  memory address
- bus_wdata  out  DW  memory write data
- bus_rdata  in  DW  memory read data
- rom_sel, ram_sel  out  1 each  region selects
- rd, wr  out  1 each  read/write strobes

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; bus_addr=0; grant=fetch; last-winner=data.
- Address map, 13-bit:
  - addr[12]=0 -> ROM
  - addr[12:11]=2'b10 -> ROM
  - addr[12:11]=2'b11 -> RAM
  - Every address maps to exactly one region; there is never a case with both selects 0 during an access.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Sample the requests. If any is pending, pick a winner, then latch its addr/we/wdata and region.
  - Write with region=ROM -> go directly to DONE with err flagged; no rd/wr strobe is issued.
  - Otherwise -> ACCESS with wait counter = WAIT(region).
- ACCESS:
  - bus_addr and the region select are stable for the whole state.
  - rd=1 for reads; wr=1 for writes; bus_wdata held.
  - Lasts WAIT+1 cycles.
  - On the last cycle, capture bus_rdata into the granted rdata register, then -> DONE.
- DONE:
  - Pulse the granted ack for 1 cycle (plus d_err if flagged).
  - rd, wr and selects are 0.
  - Next state is unconditionally IDLE. This gives one mandatory idle cycle between accesses, so a requester that drops req after ack is never double-served.
- Latency: req high at edge n -> ACCESS at n+1 .. n+1+WAIT -> ack at n+2+WAIT. An error write acks at n+1.
- Arbitration (default, feature off): fixed priority, data over fetch.
- Simultaneous if_req and d_req in IDLE: serve one; the loser stays pending and is served on the next IDLE.
- rdata registers hold their value until the next completion for that port. The non-granted ack stays 0.
- Requests changing addr/we mid-access are ignored; the values latched in IDLE are used.
- Reset asserted mid-ACCESS: rd/wr/selects drop immediately (async); no ack is issued; the requester must re-request.
- Wait counter is 3 bits and saturates at 0; never wraps.

Optional Feature:
- Macro: MEM_ARB_RR_EN
- Defined: round-robin. On a simultaneous request the port that did not win last is granted; last-winner updates on each grant (error writes included).
- Not defined: fixed data-over-fetch priority as above; last-winner register not synthesised.

Decomposition:
- Shared package mem_bus_pkg:
  - state enum {IDLE, ACCESS, DONE}
  - region enum {REG_ROM, REG_RAM}
  - AW/DW defaults
  - region boundary constants (RAM_BASE=13'h1800)
- Sub-module mem_region_decode: combinational addr -> region, used on the latched address. Shares the map with the existing decoder but stays separate so the arbiter owns its timing.

Test Plan:
- ROM_WAIT=1. Fetch read of 13'h0010 with bus_rdata=8'hA5 -> rom_sel=1 and rd=1 for 2 cycles; if_ack at n+3 with if_rdata=8'hA5.
- RAM_WAIT=0. Data write of 8'h3C to 13'h1805 -> ram_sel=1 and wr=1 for 1 cycle with bus_wdata=8'h3C; d_ack at n+2; d_err=0.
- Data write to 13'h0800 (ROM) -> no rd/wr/select; d_ack and d_err at n+1.
- if_req and d_req both raised at the same edge, held until ack:
  - Feature off: data served first, then fetch.
  - MEM_ARB_RR_EN: alternates across repeated contention; neither port waits more than one access.
- rst pulsed during the 2nd ACCESS cycle of a ROM read -> rd/rom_sel drop the same cycle; no ack; the FSM restarts in IDLE; a re-request then completes normally.
- Back-to-back fetches 13'h17FF then 13'h1800 -> first uses rom_sel, second ram_sel; one IDLE cycle between accesses; correct rdata for each.
